// File: rtl/vector_player_pkg.sv
// Shared types and helpers for the vector player and its MISR response compactor.
package vector_player_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETTLE,
        CAPTURE,
        EMIT,
        DONE
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    // Upper bounds for fold_xor operands; callers zero-extend into these.
    localparam int FOLD_MAX_IN  = 1024;
    localparam int FOLD_MAX_SIG = 64;

    // XOR of consecutive misr_w-bit chunks of the low out_w bits of data.
    function automatic logic [FOLD_MAX_SIG-1:0] fold_xor(
        input logic [FOLD_MAX_IN-1:0] data,
        input int                     out_w,
        input int                     misr_w
    );
        logic [FOLD_MAX_SIG-1:0] acc;
        logic [FOLD_MAX_SIG-1:0] mask;
        acc  = '0;
        mask = {FOLD_MAX_SIG{1'b1}} >> (FOLD_MAX_SIG - misr_w);
        for (int c = 0; c * misr_w < out_w; c++) begin
            acc = acc ^ (FOLD_MAX_SIG'(data >> (c * misr_w)) & mask);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vector_player_misr_if.sv
// Vector-memory, DUT-pin and response-stream signals of the vector player.
interface vector_player_misr_if #(
    parameter int IN_W   = 233,
    parameter int OUT_W  = 140,
    parameter int ADDR_W = $clog2(10000)
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [IN_W-1:0]   mem_rdata;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              resp_valid;
    logic [OUT_W-1:0]  resp_data;
    logic              resp_ready;

    modport master (
        output mem_rd_en, mem_addr, dut_in, resp_valid, resp_data,
        input  mem_rdata, dut_out, resp_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, dut_in, resp_valid, resp_data,
        output mem_rdata, dut_out, resp_ready
    );
endinterface

// File: rtl/misr_compactor.sv
// Multiple-input signature register: shift with polynomial feedback, then XOR in
// the chunk-folded response word. OUT_W must not exceed FOLD_MAX_IN.
module misr_compactor
    import vector_player_pkg::*;
#(
    parameter int                OUT_W  = 140,
    parameter int                MISR_W = 32,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [OUT_W-1:0]  data,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] folded;
    logic [MISR_W-1:0] feedback;
    logic [MISR_W-1:0] next_sig;

    always_comb begin
        folded   = MISR_W'(fold_xor(FOLD_MAX_IN'(data), OUT_W, MISR_W));
        feedback = sig[MISR_W-1] ? POLY : '0;
        next_sig = {sig[MISR_W-2:0], 1'b0} ^ feedback ^ folded;
    end

    // NOTE: flops use <= so every update sees the pre-edge value of sig.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= next_sig;
        end
    end

endmodule

// File: rtl/vector_player_misr.sv
// Plays stored vectors into a combinational DUT, streams each settled response
// over valid/ready and compacts it into a MISR signature.
module vector_player_misr
    import vector_player_pkg::*;
#(
    parameter int                IN_W     = 233,
    parameter int                OUT_W    = 140,
    parameter int                DEPTH    = 10000,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter int                MISR_W   = 32,
    parameter logic [MISR_W-1:0] POLY     = MISR_W'(DEFAULT_POLY),
    parameter int                SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     num_vectors,
    input  logic [SETTLE_W-1:0] settle_cycles,
    vector_player_misr_if.master bus,
    output logic [MISR_W-1:0]   signature,
    output logic [ADDR_W:0]     vec_count,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    state_t              state;
    logic [CNT_W-1:0]    num_lat;
    logic [SETTLE_W-1:0] settle_lat;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [CNT_W-1:0]    count_next;
    logic                sig_clr;
    logic                sig_en;

    assign count_next = vec_count + 1'b1;
    assign sig_clr    = (state == IDLE) && start && !abort;
    assign sig_en     = (state == CAPTURE) && !abort;
    assign busy       = (state != IDLE);

    misr_compactor #(
        .OUT_W  (OUT_W),
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (sig_clr),
        .en   (sig_en),
        .data (bus.dut_out),
        .sig  (signature)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            num_lat        <= '0;
            settle_lat     <= '0;
            settle_cnt     <= '0;
            vec_count      <= '0;
            aborted        <= 1'b0;
            done           <= 1'b0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.dut_in     <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
        end else begin
            // NOTE: strobes default low every cycle; only the entering transition raises them.
            bus.mem_rd_en <= 1'b0;
            done          <= 1'b0;

            if (abort && state != IDLE) begin
                // Abort beats a same-cycle handshake, so vec_count and signature freeze.
                state          <= IDLE;
                bus.resp_valid <= 1'b0;
                aborted        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            num_lat      <= (num_vectors > DEPTH_CNT) ? DEPTH_CNT : num_vectors;
                            settle_lat   <= settle_cycles;
                            vec_count    <= '0;
                            aborted      <= 1'b0;
                            bus.mem_addr <= '0;
                            if (num_vectors == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state         <= FETCH;
                                bus.mem_rd_en <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        bus.dut_in <= bus.mem_rdata;
                        settle_cnt <= (settle_lat == '0) ? SETTLE_W'(1) : settle_lat;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt - 1'b1;
                        if (settle_cnt == SETTLE_W'(1)) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        bus.resp_data  <= bus.dut_out;
                        bus.resp_valid <= 1'b1;
                        state          <= EMIT;
                    end
                    EMIT: begin
                        if (bus.resp_ready) begin
                            vec_count      <= count_next;
                            bus.resp_valid <= 1'b0;
                            if (count_next == num_lat) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                // count_next < num_lat <= DEPTH, so the address never wraps.
                                state         <= FETCH;
                                bus.mem_rd_en <= 1'b1;
                                bus.mem_addr  <= count_next[ADDR_W-1:0];
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
